// File: rtl/core_config_pkg.sv
// Core-wide configuration: widths, CSR addresses, trap sequencer states and
// the MSTATUS bit layout used when a trap is entered or left.
package core_config_pkg;

  localparam int XLEN  = 32;
  localparam int IRQ_W = 3;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  typedef enum logic [11:0] {
    r_NONE    = 12'h000,
    r_MSTATUS = 12'h300,
    r_MEPC    = 12'h341,
    r_MCAUSE  = 12'h342,
    r_MTVAL   = 12'h343
  } csr_t;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    M_MSTATUS,
    REDIRECT
  } trap_state_t;

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE_BIT]       = ms[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]        = 1'b0;
    r[MSTATUS_MPP_LSB +: 2]   = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE_BIT]        = ms[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT]       = 1'b1;
    r[MSTATUS_MPP_LSB +: 2]   = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Interrupt pending/priority encoder: MEI > MSI > MTI, gated by the global
// enable and the per-line enables.
module irq_prio
  import core_config_pkg::*;
(
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [IRQ_W-1:0] irq_en,
  input  logic             glob_en,
  output logic             valid,
  output logic [4:0]       cause
);

  logic [IRQ_W-1:0] pend;

  assign pend = irq_i & irq_en & {IRQ_W{glob_en}};

  always_comb begin
    valid = |pend;
    cause = '0;
    if (pend[2])      cause = CAUSE_MEI;
    else if (pend[0]) cause = CAUSE_MSI;
    else if (pend[1]) cause = CAUSE_MTI;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes MEPC/MCAUSE/MTVAL/MSTATUS one per cycle,
// then flushes and redirects. Vectored interrupts need TRAP_VECTORED_EN.
//
// state     | meaning
// IDLE      | waiting for exception / MRET / enabled interrupt
// W_MEPC    | writing MEPC
// W_MCAUSE  | writing MCAUSE
// W_MTVAL   | writing MTVAL
// W_MSTATUS | writing trap-entry MSTATUS
// M_MSTATUS | writing MRET MSTATUS
// REDIRECT  | PC redirect strobe
module trap_ctrl
  import core_config_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_valid_i,
  input  logic [4:0]       exc_cause_i,
  input  logic [XLEN-1:0]  exc_pc_i,
  input  logic [XLEN-1:0]  exc_tval_i,
  input  logic             mret_i,
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [XLEN-1:0]  irq_pc_i,
  input  logic [XLEN-1:0]  mstatus_i,
  input  logic [XLEN-1:0]  mie_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic             exc_ack_o,
  output logic             busy_o,
  output logic             csr_we_o,
  output csr_t             csr_waddr_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o
);

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d, tval_q, tval_d;
  logic            ack_d, we_d, rv_d, busy_d;
  csr_t            waddr_d;
  logic [XLEN-1:0] wdata_d, rpc_d;
  logic            irq_valid;
  logic [4:0]      irq_cause;
  logic [XLEN-1:0] trap_base, trap_target;
  logic            unused_bits;

  assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};

  irq_prio u_irq_prio (
    .irq_i   (irq_i),
    .irq_en  ({mie_i[11], mie_i[7], mie_i[3]}),
    .glob_en (mstatus_i[MSTATUS_MIE_BIT]),
    .valid   (irq_valid),
    .cause   (irq_cause)
  );

  assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_target = (cause_q[XLEN-1] && mtvec_i[0]) ?
                       trap_base + XLEN'({cause_q[4:0], 2'b00}) : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cause_q          <= '0;
      tval_q           <= '0;
      exc_ack_o        <= 1'b0;
      busy_o           <= 1'b0;
      flush_o          <= 1'b0;
      csr_we_o         <= 1'b0;
      csr_waddr_o      <= r_NONE;
      csr_wdata_o      <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      tval_q           <= tval_d;
      exc_ack_o        <= ack_d;
      busy_o           <= busy_d;
      flush_o          <= busy_d;
      csr_we_o         <= we_d;
      csr_waddr_o      <= waddr_d;
      csr_wdata_o      <= wdata_d;
      redirect_valid_o <= rv_d;
      redirect_pc_o    <= rpc_d;
    end
  end

  // Outputs are computed for the state being entered so that the registered
  // copies line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    ack_d   = 1'b0;
    we_d    = 1'b0;
    waddr_d = r_NONE;
    wdata_d = '0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          state_d = W_MEPC;
          cause_d = XLEN'(exc_cause_i);
          tval_d  = exc_tval_i;
          ack_d   = 1'b1;
          we_d    = 1'b1;
          waddr_d = r_MEPC;
          wdata_d = exc_pc_i;
        end else if (mret_i) begin
          state_d = M_MSTATUS;
          ack_d   = 1'b1;
          we_d    = 1'b1;
          waddr_d = r_MSTATUS;
          wdata_d = mret_mstatus(mstatus_i);
        end else if (irq_valid) begin
          state_d = W_MEPC;
          cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_cause};
          tval_d  = '0;
          ack_d   = 1'b1;
          we_d    = 1'b1;
          waddr_d = r_MEPC;
          wdata_d = irq_pc_i;
        end
      end
      W_MEPC: begin
        state_d = W_MCAUSE;
        we_d    = 1'b1;
        waddr_d = r_MCAUSE;
        wdata_d = cause_q;
      end
      W_MCAUSE: begin
        state_d = W_MTVAL;
        we_d    = 1'b1;
        waddr_d = r_MTVAL;
        wdata_d = tval_q;
      end
      W_MTVAL: begin
        state_d = W_MSTATUS;
        we_d    = 1'b1;
        waddr_d = r_MSTATUS;
        wdata_d = trap_mstatus(mstatus_i);
      end
      W_MSTATUS: begin
        state_d = REDIRECT;
        rv_d    = 1'b1;
        rpc_d   = trap_target;
      end
      M_MSTATUS: begin
        state_d = REDIRECT;
        rv_d    = 1'b1;
        rpc_d   = mepc_i;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: drives on the falling edge, checks all
// outputs on the falling edge of each cycle against hand-computed values.
module tb_trap_ctrl;
  import core_config_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             exc_valid_i;
  logic [4:0]       exc_cause_i;
  logic [XLEN-1:0]  exc_pc_i;
  logic [XLEN-1:0]  exc_tval_i;
  logic             mret_i;
  logic [IRQ_W-1:0] irq_i;
  logic [XLEN-1:0]  irq_pc_i;
  logic [XLEN-1:0]  mstatus_i;
  logic [XLEN-1:0]  mie_i;
  logic [XLEN-1:0]  mtvec_i;
  logic [XLEN-1:0]  mepc_i;
  logic             exc_ack_o;
  logic             busy_o;
  logic             csr_we_o;
  csr_t             csr_waddr_o;
  logic [XLEN-1:0]  csr_wdata_o;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] MTI_TARGET = 32'h1000_021C;
`else
  localparam logic [31:0] MTI_TARGET = 32'h1000_0200;
`endif

  trap_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .mret_i           (mret_i),
    .irq_i            (irq_i),
    .irq_pc_i         (irq_pc_i),
    .mstatus_i        (mstatus_i),
    .mie_i            (mie_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .exc_ack_o        (exc_ack_o),
    .busy_o           (busy_o),
    .csr_we_o         (csr_we_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ack, input logic busy,
                            input logic we, input csr_t addr, input logic [31:0] wdata,
                            input logic rv, input logic [31:0] rpc);
    chk({tag, ".ack"},   32'(exc_ack_o),        32'(ack));
    chk({tag, ".busy"},  32'(busy_o),           32'(busy));
    chk({tag, ".flush"}, 32'(flush_o),          32'(busy));
    chk({tag, ".we"},    32'(csr_we_o),         32'(we));
    chk({tag, ".addr"},  32'(csr_waddr_o),      32'(addr));
    chk({tag, ".wdata"}, csr_wdata_o,           wdata);
    chk({tag, ".rv"},    32'(redirect_valid_o), 32'(rv));
    chk({tag, ".rpc"},   redirect_pc_o,         rpc);
  endtask

  initial begin
    rst_n = 1'b0; exc_valid_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0;
    mret_i = 1'b0; irq_i = '0; irq_pc_i = '0; mstatus_i = '0; mie_i = '0;
    mtvec_i = '0; mepc_i = '0;
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, r_NONE, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("idle0", 0, 0, 0, r_NONE, 0, 0, 0);

    // ECALL with MIE=1
    mstatus_i = 32'h8; mtvec_i = 32'h1000_0100;
    exc_cause_i = 5'd11; exc_pc_i = 32'h1000_0040; exc_tval_i = 32'h0; exc_valid_i = 1'b1;
    @(negedge clk); expect_out("ecall.c1", 1, 1, 1, r_MEPC, 32'h1000_0040, 0, 0);
    exc_valid_i = 1'b0;
    @(negedge clk); expect_out("ecall.c2", 0, 1, 1, r_MCAUSE, 32'd11, 0, 0);
    @(negedge clk); expect_out("ecall.c3", 0, 1, 1, r_MTVAL, 32'h0, 0, 0);
    @(negedge clk); expect_out("ecall.c4", 0, 1, 1, r_MSTATUS, 32'h1880, 0, 0);
    @(negedge clk); expect_out("ecall.c5", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0100);
    @(negedge clk); expect_out("ecall.c6", 0, 0, 0, r_NONE, 0, 0, 0);

    // Timer interrupt, mtvec in vectored mode
    mie_i = 32'h80; irq_pc_i = 32'h1000_0080; mtvec_i = 32'h1000_0201; irq_i = 3'b010;
    @(negedge clk); expect_out("mti.c1", 1, 1, 1, r_MEPC, 32'h1000_0080, 0, 0);
    irq_i = 3'b000;
    @(negedge clk); expect_out("mti.c2", 0, 1, 1, r_MCAUSE, 32'h8000_0007, 0, 0);
    @(negedge clk); expect_out("mti.c3", 0, 1, 1, r_MTVAL, 32'h0, 0, 0);
    @(negedge clk); expect_out("mti.c4", 0, 1, 1, r_MSTATUS, 32'h1880, 0, 0);
    @(negedge clk); expect_out("mti.c5", 0, 1, 0, r_NONE, 0, 1, MTI_TARGET);
    @(negedge clk); expect_out("mti.c6", 0, 0, 0, r_NONE, 0, 0, 0);

    // MRET with MPIE=1, MIE=0
    mie_i = 32'h0; mstatus_i = 32'h80; mepc_i = 32'h1000_0044; mret_i = 1'b1;
    @(negedge clk); expect_out("mret.c1", 1, 1, 1, r_MSTATUS, 32'h1888, 0, 0);
    mret_i = 1'b0;
    @(negedge clk); expect_out("mret.c2", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0044);
    @(negedge clk); expect_out("mret.c3", 0, 0, 0, r_NONE, 0, 0, 0);

    // Exception together with all interrupts pending: exception wins
    mstatus_i = 32'h8; mie_i = 32'h888; irq_i = 3'b111; mtvec_i = 32'h1000_0100;
    irq_pc_i = 32'h1000_0080;
    exc_cause_i = 5'd2; exc_pc_i = 32'h1000_0010; exc_tval_i = 32'hDEAD_BEEF; exc_valid_i = 1'b1;
    @(negedge clk); expect_out("exirq.c1", 1, 1, 1, r_MEPC, 32'h1000_0010, 0, 0);
    exc_valid_i = 1'b0;
    @(negedge clk); expect_out("exirq.c2", 0, 1, 1, r_MCAUSE, 32'd2, 0, 0);
    @(negedge clk); expect_out("exirq.c3", 0, 1, 1, r_MTVAL, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk); expect_out("exirq.c4", 0, 1, 1, r_MSTATUS, 32'h1880, 0, 0);
    mstatus_i = 32'h1880;
    @(negedge clk); expect_out("exirq.c5", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0100);
    @(negedge clk); expect_out("exirq.c6", 0, 0, 0, r_NONE, 0, 0, 0);
    @(negedge clk); expect_out("mie0.c7", 0, 0, 0, r_NONE, 0, 0, 0);
    @(negedge clk); expect_out("mie0.c8", 0, 0, 0, r_NONE, 0, 0, 0);

    // Re-enable MIE: MEI has priority
    mstatus_i = 32'h8;
    @(negedge clk); expect_out("mei.c1", 1, 1, 1, r_MEPC, 32'h1000_0080, 0, 0);
    irq_i = 3'b000;
    @(negedge clk); expect_out("mei.c2", 0, 1, 1, r_MCAUSE, 32'h8000_000B, 0, 0);
    @(negedge clk); expect_out("mei.c3", 0, 1, 1, r_MTVAL, 32'h0, 0, 0);
    @(negedge clk); expect_out("mei.c4", 0, 1, 1, r_MSTATUS, 32'h1880, 0, 0);
    @(negedge clk); expect_out("mei.c5", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0100);
    @(negedge clk); expect_out("mei.c6", 0, 0, 0, r_NONE, 0, 0, 0);

    // MSI beats MTI
    irq_i = 3'b011;
    @(negedge clk); expect_out("msi.c1", 1, 1, 1, r_MEPC, 32'h1000_0080, 0, 0);
    irq_i = 3'b000;
    @(negedge clk); expect_out("msi.c2", 0, 1, 1, r_MCAUSE, 32'h8000_0003, 0, 0);
    repeat (4) @(negedge clk);
    expect_out("msi.c6", 0, 0, 0, r_NONE, 0, 0, 0);

    // Exception and MRET together: exception first, MRET afterwards
    mie_i = 32'h0; mstatus_i = 32'h80; mepc_i = 32'h1000_0044;
    exc_cause_i = 5'd3; exc_pc_i = 32'h1000_0020; exc_tval_i = 32'h1000_0020;
    exc_valid_i = 1'b1; mret_i = 1'b1;
    @(negedge clk); expect_out("exmret.c1", 1, 1, 1, r_MEPC, 32'h1000_0020, 0, 0);
    exc_valid_i = 1'b0;
    @(negedge clk); expect_out("exmret.c2", 0, 1, 1, r_MCAUSE, 32'd3, 0, 0);
    @(negedge clk); expect_out("exmret.c3", 0, 1, 1, r_MTVAL, 32'h1000_0020, 0, 0);
    @(negedge clk); expect_out("exmret.c4", 0, 1, 1, r_MSTATUS, 32'h1800, 0, 0);
    @(negedge clk); expect_out("exmret.c5", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0100);
    @(negedge clk); expect_out("exmret.c6", 0, 0, 0, r_NONE, 0, 0, 0);
    @(negedge clk); expect_out("exmret.c7", 1, 1, 1, r_MSTATUS, 32'h1888, 0, 0);
    mret_i = 1'b0;
    @(negedge clk); expect_out("exmret.c8", 0, 1, 0, r_NONE, 0, 1, 32'h1000_0044);
    @(negedge clk); expect_out("exmret.c9", 0, 0, 0, r_NONE, 0, 0, 0);

    // Reset asserted while in W_MCAUSE
    mstatus_i = 32'h8; exc_cause_i = 5'd0; exc_pc_i = 32'h1000_0050; exc_tval_i = 32'h0;
    exc_valid_i = 1'b1;
    @(negedge clk); expect_out("rstmid.c1", 1, 1, 1, r_MEPC, 32'h1000_0050, 0, 0);
    exc_valid_i = 1'b0;
    @(negedge clk); expect_out("rstmid.c2", 0, 1, 1, r_MCAUSE, 32'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1 expect_out("rstmid.async", 0, 0, 0, r_NONE, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); expect_out("rstmid.idle1", 0, 0, 0, r_NONE, 0, 0, 0);
    @(negedge clk); expect_out("rstmid.idle2", 0, 0, 0, r_NONE, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
